// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 single-bit mux. Each grant is bounded to MAX_HOLD cycles while others wait.
// Optional MUX_ARB_LOCK_EN adds a lock input that suppresses the timeout release.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       out,
  output logic       valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       sel_nxt;
  logic [1:0]       owner;
  logic             lock_act;
  logic             others;
  logic             timeout;
  logic             arb;
  logic [1:0]       base;
  logic [3:0]       mask;
  logic [2:0]       pick;

`ifdef MUX_ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(MAX_HOLD)) sat_inc = CNT_W'(MAX_HOLD);
    else                       sat_inc = c + CNT_W'(1);
  endfunction

  // Returns {found, index}: first set bit of r scanning p, p+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] k;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) rr_pick = {1'b1, k};
    end
  endfunction

  assign owner   = {s0, s1};
  assign others  = |(req & ~onehot(owner));
  assign timeout = (cnt == CNT_W'(MAX_HOLD)) && others && !lock_act;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    sel_nxt   = owner;
    arb       = 1'b0;
    base      = ptr;
    mask      = req;
    pick      = 3'b000;
    case (state)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (req[owner] && !timeout) begin
          cnt_nxt = sat_inc(cnt);
        end else begin
          // Masking the owner is a no-op on a req drop and enforces exclusion on timeout.
          ptr_nxt = owner + 2'd1;
          base    = owner + 2'd1;
          mask    = req & ~onehot(owner);
          arb     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (arb) begin
      pick = rr_pick(mask, base);
      if (pick[2]) begin
        gnt_nxt   = onehot(pick[1:0]);
        sel_nxt   = pick[1:0];
        cnt_nxt   = CNT_W'(1);
        state_nxt = GRANT;
      end else begin
        gnt_nxt   = 4'b0000;
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      gnt   <= 4'b0000;
      s0    <= 1'b0;
      s1    <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      s0    <= sel_nxt[1];
      s1    <= sel_nxt[0];
    end
  end

  assign valid = |gnt;
  assign out   = valid & din[owner];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed, table-driven bench for mux4_rr_arbiter (MAX_HOLD=8); lock sequence is built with MUX_ARB_LOCK_EN.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       s0, s1, out, valid;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif

  int n_tot  = 0;
  int n_pass = 0;
  int n_fail = 0;

  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
`ifdef MUX_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .s0    (s0),
    .s1    (s1),
    .out   (out),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out;
    logic       valid;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string nm, input logic [3:0] eg, input logic [1:0] es,
                         input logic eo, input logic ev);
    chk({nm, ".gnt"},   gnt, eg);
    chk({nm, ".sel"},   {2'b00, s0, s1}, {2'b00, es});
    chk({nm, ".out"},   {3'b000, out}, {3'b000, eo});
    chk({nm, ".valid"}, {3'b000, valid}, {3'b000, ev});
  endtask

  initial begin
    logic [3:0] pat;
    logic [1:0] o;

    tbl[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
    tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 2'b10, 1'b0, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0};
    tbl[3]  = '{4'b0011, 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b1};
    tbl[4]  = '{4'b0011, 4'b0010, 4'b0001, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{4'b0011, 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b1};
    tbl[6]  = '{4'b0010, 4'b0010, 4'b0010, 2'b01, 1'b1, 1'b1};
    tbl[7]  = '{4'b1010, 4'b0000, 4'b0010, 2'b01, 1'b0, 1'b1};
    tbl[8]  = '{4'b1000, 4'b1000, 4'b1000, 2'b11, 1'b1, 1'b1};
    tbl[9]  = '{4'b0001, 4'b0000, 4'b0001, 2'b00, 1'b0, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 4'b1111;
    din   = 4'b1111;
`ifdef MUX_ARB_LOCK_EN
    lock  = 1'b0;
`endif

    // Reset state with all requests pending
    repeat (2) @(negedge clk);
    chk_all("reset", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Release reset; full contention round-robin for 40 cycles
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      pat = 4'((c * 7 + 5) % 16);
      din = pat;
      tick();
      o = 2'((c / 8) % 4);
      chk_all($sformatf("rr%0d", c), 4'b0001 << o, o, pat[o], 1'b1);
    end

    req = 4'b0000;
    tick();
    chk_all("rr_drop", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Directed table: single request, idle, early handover, simultaneous drop/arrive
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      din = tbl[i].din;
      tick();
      chk_all($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].out, tbl[i].valid);
    end

    // Sole requester is never timed out
    req = 4'b1000;
    din = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("sole%0d.gnt", c), gnt, 4'b1000);
    end
    chk("sole.out", {3'b000, out}, 4'b0001);
    req = 4'b1010;
    tick();
    chk_all("sole_handover", 4'b0010, 2'b01, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle drops the grant without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle.gnt", gnt, 4'b0000);

`ifdef MUX_ARB_LOCK_EN
    // Lock keeps requester 0 past the hold limit
    lock = 1'b1;
    req  = 4'b0011;
    din  = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("lock%0d.gnt", c), gnt, 4'b0001);
    end
    lock = 1'b0;
    tick();
    chk_all("unlock", 4'b0010, 2'b01, 1'b0, 1'b1);
`else
    // Timeout boundary: requester 0 holds exactly 8 cycles, then hands over
    req = 4'b0011;
    din = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("hold%0d.gnt", c), gnt, 4'b0001);
    end
    tick();
    chk_all("timeout", 4'b0010, 2'b01, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Cycle-by-cycle controller for the shared 4:1 single-bit mux resource (select pair s0/s1).
- Arbitrates four requesters with a round-robin scheduler.
- Drives the mux selects, issues one-hot grants and forwards the granted requester's data bit.
- Bounds each grant to MAX_HOLD cycles when other requesters are waiting, so no requester starves.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles while another request is pending; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the hold counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  request per requester; bit k = requester k; level-sensitive, held until done.
- din  in  4  data bit per requester; din[k] maps to mux input ik.
- gnt  out  4  one-hot grant, registered; all zero when idle.
- s0  out  1  mux select MSB, registered.
- s1  out  1  mux select LSB, registered.
- out  out  1  forwarded data; equals din[2*s0+s1] when valid=1, else 0; combinational from registered selects.
- valid  out  1  high while any grant is held; equals |gnt.
- lock  in  1  grant extension request; present only with MUX_ARB_LOCK_EN.

Behaviour:
- Select encoding (fixed by the mux): index = 2*s0 + s1. i0 = (s0=0, s1=0); i1 = (0, 1); i2 = (1, 0); i3 = (1, 1).
- Reset (async, rst_n=0): gnt=0, s0=0, s1=0, valid=0, out=0, state=IDLE, ptr=0, cnt=0.
  - Deassertion is sampled on the clock.
  - Reset mid-grant drops the grant immediately, with no completion cycle.
- State IDLE (gnt=0):
  - If req != 0, the winner is the first k with req[k]=1, scanning ptr, ptr+1, ... mod 4.
  - Next edge: gnt=onehot(winner), {s0,s1}=winner, cnt=1, go to GRANT.
  - Latency from req rising to gnt is 1 cycle.
- State GRANT (owner o):
  - cnt increments each cycle and saturates at MAX_HOLD.
  - Release condition: req[o]=0, or (cnt==MAX_HOLD and any other req bit is set).
  - On release: ptr <= (o+1) mod 4, and arbitration runs in the same cycle from the new ptr, excluding o when the release is by timeout.
  - If a winner exists, the next edge loads the new grant directly, with no idle bubble between back-to-back grants.
  - If no winner exists, go to IDLE with gnt=0. s0/s1 hold their last value; out is forced to 0 via valid.
- Sole requester: when req[o] is the only request, cnt==MAX_HOLD does not release. The grant persists and cnt stays saturated.
- Simultaneous events:
  - A req deassert and a new req arriving in the same cycle cause a handover at the next edge.
  - A req rising in the cycle of its own release is ignored by the exclusion and served in a later round.
- Fairness: with all four requesting continuously, the grant order is 0, 1, 2, 3, 0, ..., each for exactly MAX_HOLD cycles.
- gnt, s0, s1 and valid always change on the same edge and never disagree.
- out tracks din of the owner combinationally within the cycle.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - lock port exists.
  - While in GRANT with lock=1, the timeout release is suppressed; the owner keeps the grant past MAX_HOLD and cnt stays saturated.
  - Release by req[o]=0 still applies.
  - lock is ignored in IDLE.
- Undefined:
  - No lock port.
  - Timeout release is always active as described above.

Test Plan:
- Reset values: hold rst_n=0 with req=4'b1111 -> gnt=0, s0=s1=0, valid=0, out=0. Release reset -> the cycle after, gnt=4'b0001, s0=0, s1=0.
- Single request: req=4'b0100, din=4'b0100 -> one cycle later gnt=4'b0100, s0=1, s1=0, out=1. Drop req -> next cycle gnt=0, valid=0.
- Round-robin under contention (MAX_HOLD=8): req=4'b1111 held for 40 cycles -> grants 0, 1, 2, 3, 0 in order, 8 cycles each, and the select pair steps 00, 01, 10, 11.
- Early release and handover: req=4'b0011; requester 0 drops req after 3 cycles -> gnt moves to 4'b0010 on the next edge with no zero-gnt cycle.
- Sole requester past limit: only req[3]=1 for 20 cycles -> gnt=4'b1000 continuously. Raise req[1] at cycle 20 -> gnt=4'b0010 one cycle later.
- Async reset mid-grant: assert rst_n=0 mid-cycle while gnt=4'b0010 -> gnt=0 and valid=0 immediately, without waiting for a clock edge. With MUX_ARB_LOCK_EN and lock=1, req=4'b0011 -> requester 0 holds beyond 8 cycles; lock=0 -> release on the next edge.
